// File: rtl/cnn_pkg.sv
// Shared types and helpers for the streaming CNN classifier: state codes,
// width helpers and the default geometry.
package cnn_pkg;
  localparam int IMG_W_DEF  = 16;
  localparam int FEAT_W_DEF = 4;

  typedef logic [1:0] state_t;
  localparam state_t S_LOAD = 2'd0;
  localparam state_t S_CONV = 2'd1;
  localparam state_t S_POOL = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int sat_resize(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // Wide enough for every pooled element at full scale.
  function automatic int score_w(input int img_w, input int feat_w);
    return clog2((img_w / 2) * (img_w / 2) * ((1 << feat_w) - 1) + 1);
  endfunction
endpackage

// File: rtl/cnn_stream_classifier_if.sv
// Row-input / result-output handshake bundle of the streaming CNN classifier.
interface cnn_stream_classifier_if import cnn_pkg::*; #(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int FEAT_W = FEAT_W_DEF
);
  localparam int SCORE_W = score_w(IMG_W, FEAT_W);

  logic               in_valid;
  logic               in_ready;
  logic [IMG_W-1:0]   in_row;
  logic               out_valid;
  logic               out_ready;
  logic               result;
  logic [SCORE_W-1:0] score;
  logic               busy;

  modport slave  (input in_valid, in_row, out_ready,
                  output in_ready, out_valid, result, score, busy);
  modport master (output in_valid, in_row, out_ready,
                  input in_ready, out_valid, result, score, busy);
endinterface

// File: rtl/cnn_conv3x3_pe.sv
// One 3x3 binary-mask popcount, saturated to FEAT_W bits.
module cnn_conv3x3_pe import cnn_pkg::*; #(
  parameter int         FEAT_W = FEAT_W_DEF,
  parameter logic [8:0] KERNEL = 9'h1FF
) (
  input  logic [8:0]        win,
  output logic [FEAT_W-1:0] feat
);
  assign feat = FEAT_W'(sat_resize($countones(win & KERNEL), FEAT_W));
endmodule

// File: rtl/cnn_stream_classifier.sv
// Frame-buffered conv3x3 -> implicit zero pad -> 2x2 maxpool -> threshold classifier.
// Optional CNN_FRAME_CNT_EN adds a 16-bit count of delivered results.
module cnn_stream_classifier import cnn_pkg::*; #(
  parameter int          IMG_W  = IMG_W_DEF,
  parameter int          FEAT_W = FEAT_W_DEF,
  parameter logic [8:0]  KERNEL = 9'h1FF,
  parameter int unsigned THRESH = 300
) (
  input logic clk,
  input logic rst,
  cnn_stream_classifier_if.slave bus
`ifdef CNN_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);
  localparam int SCORE_W = score_w(IMG_W, FEAT_W);
  localparam int CW      = clog2(IMG_W);
  localparam logic [CW-1:0] ROW_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(IMG_W - 3);
  localparam logic [CW-1:0] POOL_LAST = CW'(IMG_W / 2 - 1);
  localparam logic [CW-1:0] FEAT_MAX  = CW'(IMG_W - 2);

  state_t             state;
  logic [CW-1:0]      row, ci, cj, pa, pb;
  logic [SCORE_W-1:0] acc, acc_nxt;
  logic [IMG_W-1:0]   img  [IMG_W];
  logic [FEAT_W-1:0]  feat [IMG_W][IMG_W];
  logic [8:0]         win;
  logic [FEAT_W-1:0]  f, q, m0, m1;
  logic [FEAT_W-1:0]  pv [4];
  logic               row_hs, out_hs;

  assign bus.in_ready = (state == S_LOAD) && !rst;
  assign bus.busy     = (state != S_LOAD);
  assign row_hs       = bus.in_valid && bus.in_ready;
  assign out_hs       = bus.out_valid && bus.out_ready;

  for (genvar kr = 0; kr < 3; kr++) begin : g_wr
    for (genvar kc = 0; kc < 3; kc++) begin : g_wc
      assign win[3*kr+kc] = img[ci + CW'(kr)][cj + CW'(kc)];
    end
  end

  cnn_conv3x3_pe #(.FEAT_W(FEAT_W), .KERNEL(KERNEL)) u_pe (.win(win), .feat(f));

  // Padded coordinate (r,c) maps to feature (r-1,c-1); the border reads as zero.
  for (genvar d = 0; d < 4; d++) begin : g_pool
    logic [CW-1:0] r, c;
    assign r = (pa << 1) | CW'(d / 2);
    assign c = (pb << 1) | CW'(d % 2);
    assign pv[d] = (r != '0 && r <= FEAT_MAX && c != '0 && c <= FEAT_MAX)
                   ? feat[r - CW'(1)][c - CW'(1)] : '0;
  end

  assign m0      = (pv[0] > pv[1]) ? pv[0] : pv[1];
  assign m1      = (pv[2] > pv[3]) ? pv[2] : pv[3];
  assign q       = (m0 > m1) ? m0 : m1;
  assign acc_nxt = acc + SCORE_W'(q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_LOAD;
      row           <= '0;
      ci            <= '0;
      cj            <= '0;
      pa            <= '0;
      pb            <= '0;
      acc           <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= 1'b0;
      bus.score     <= '0;
    end else begin
      case (state)
        S_LOAD: if (row_hs) begin
          row <= row + CW'(1);
          if (row == ROW_LAST) begin
            row   <= '0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          if (cj == CONV_LAST) begin
            cj <= '0;
            ci <= ci + CW'(1);
            if (ci == CONV_LAST) begin
              ci    <= '0;
              state <= S_POOL;
            end
          end else cj <= cj + CW'(1);
        end
        S_POOL: begin
          acc <= acc_nxt;
          if (pb == POOL_LAST) begin
            pb <= '0;
            pa <= pa + CW'(1);
            if (pa == POOL_LAST) begin
              pa            <= '0;
              state         <= S_DONE;
              bus.out_valid <= 1'b1;
              bus.score     <= acc_nxt;
              bus.result    <= 32'(acc_nxt) > THRESH;
            end
          end else pb <= pb + CW'(1);
        end
        S_DONE: if (out_hs) begin
          state         <= S_LOAD;
          bus.out_valid <= 1'b0;
          acc           <= '0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Buffers need no reset: a frame is only consumed after all rows are rewritten.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && row_hs) img[row] <= bus.in_row;
    if (state == S_CONV) feat[ci][cj] <= f;
  end

`ifdef CNN_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         frame_cnt <= '0;
    else if (out_hs) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cnn_stream_classifier.sv
// Randomized self-checking bench for cnn_stream_classifier against a plain
// arithmetic reference of conv / pad / pool / threshold.
module tb_cnn_stream_classifier;
  import cnn_pkg::*;
  localparam int          IMG_W   = 16;
  localparam int          FEAT_W  = 4;
  localparam logic [8:0]  KERNEL  = 9'h1FF;
  localparam int unsigned THRESH  = 300;
  localparam int          SCORE_W = score_w(IMG_W, FEAT_W);
  localparam int          LAT     = (IMG_W-2)*(IMG_W-2) + (IMG_W/2)*(IMG_W/2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_stream_classifier_if #(.IMG_W(IMG_W), .FEAT_W(FEAT_W)) bus ();
`ifdef CNN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  cnn_stream_classifier #(.IMG_W(IMG_W), .FEAT_W(FEAT_W), .KERNEL(KERNEL), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef CNN_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_frames = 0;
  logic [IMG_W-1:0] img [IMG_W];

  // Reference: build the zero-padded feature map, then max over 2x2 blocks.
  function automatic int ref_score();
    int p [IMG_W][IMG_W];
    int s, sum, m, fmax;
    logic [8:0] k;
    k = KERNEL;
    fmax = (1 << FEAT_W) - 1;
    s = 0;
    for (int r = 0; r < IMG_W; r++) for (int c = 0; c < IMG_W; c++) p[r][c] = 0;
    for (int i = 0; i < IMG_W-2; i++)
      for (int j = 0; j < IMG_W-2; j++) begin
        sum = 0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            if (img[i+kr][j+kc] && k[3*kr+kc]) sum++;
        p[i+1][j+1] = (sum > fmax) ? fmax : sum;
      end
    for (int a = 0; a < IMG_W/2; a++)
      for (int b = 0; b < IMG_W/2; b++) begin
        m = 0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (p[2*a+dr][2*b+dc] > m) m = p[2*a+dr][2*b+dc];
        s += m;
      end
    return s;
  endfunction

  task automatic send_frame(input bit gaps);
    int r, guard;
    bit hs;
    r = 0;
    guard = 0;
    while (r < IMG_W && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_row   = IMG_W'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_row   = img[r];
      end
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) r++;
    end
    #1 bus.in_valid = 1'b0;
    n_cmp++;
    if (r != IMG_W) begin
      n_err++;
      $display("FAIL send_frame: rows accepted %0d, required %0d", r, IMG_W);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.out_valid) break;
    end
  endtask

  task automatic check_frame(input string name, input int exp_score);
    int lat;
    wait_out(lat);
    n_cmp += 4;
    if (lat !== LAT) begin
      n_err++; $display("FAIL %s latency: got %0d, required %0d", name, lat, LAT);
    end
    if (32'(bus.score) !== 32'(exp_score)) begin
      n_err++; $display("FAIL %s score: got %0d, required %0d", name, bus.score, exp_score);
    end
    if (bus.result !== (exp_score > int'(THRESH))) begin
      n_err++; $display("FAIL %s result: got %0b, required %0b", name, bus.result, exp_score > int'(THRESH));
    end
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL %s done_flags: in_ready=%0b busy=%0b, required 0/1", name, bus.in_ready, bus.busy);
    end
  endtask

  task automatic ack(input string name);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    exp_frames++;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s ack: out_valid=%0b in_ready=%0b, required 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_W; r++)
      img[r] = ($urandom_range(0, 1) == 0) ? IMG_W'($urandom) : IMG_W'($urandom | $urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_row = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.result !== 1'b0 || bus.score !== '0 || bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_state: ov=%0b res=%0b score=%0d rdy=%0b, required 0/0/0/0",
                        bus.out_valid, bus.result, bus.score, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL reset_release: rdy=%0b busy=%0b, required 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_all_zero();
    for (int r = 0; r < IMG_W; r++) img[r] = '0;
    send_frame(1'b0);
    check_frame("all_zero", 0);
    ack("all_zero");
  endtask

  task automatic test_all_ones();
    for (int r = 0; r < IMG_W; r++) img[r] = '1;
    n_cmp++;
    if (ref_score() != 576) begin
      n_err++; $display("FAIL all_ones_model: got %0d, required 576", ref_score());
    end
    send_frame(1'b0);
    check_frame("all_ones", 576);
    ack("all_ones");
  endtask

  task automatic test_single_pixel();
    for (int r = 0; r < IMG_W; r++) img[r] = '0;
    img[5][5] = 1'b1;
    send_frame(1'b0);
    check_frame("single_pixel", 4);
    ack("single_pixel");
  endtask

  task automatic test_backpressure();
    int exp, bad;
    fill_random();
    exp = ref_score();
    send_frame(1'b0);
    check_frame("backpressure", exp);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_row = IMG_W'($urandom);
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b1 || 32'(bus.score) !== 32'(exp) || bus.in_ready !== 1'b0 ||
          bus.result !== (exp > int'(THRESH))) bad++;
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
    end
    ack("backpressure");
    fill_random();
    send_frame(1'b0);
    check_frame("after_backpressure", ref_score());
    ack("after_backpressure");
  endtask

  task automatic test_reset_mid_conv();
    fill_random();
    send_frame(1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_err++; $display("FAIL midreset_ready: got %0b, required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL midreset_state: ov=%0b busy=%0b, required 0/0", bus.out_valid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_frames = 0;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_release: rdy=%0b ov=%0b, required 1/0", bus.in_ready, bus.out_valid);
    end
    for (int r = 0; r < IMG_W; r++) img[r] = '1;
    send_frame(1'b0);
    check_frame("after_midreset", 576);
    ack("after_midreset");
  endtask

  task automatic test_random_gaps();
    pulse_reset();
    for (int n = 0; n < 3; n++) begin
      fill_random();
      send_frame(1'b1);
      check_frame($sformatf("gaps_%0d", n), ref_score());
      ack("gaps");
    end
`ifdef CNN_FRAME_CNT_EN
    n_cmp++;
    if (32'(frame_cnt) !== 32'(exp_frames) || exp_frames != 3) begin
      n_err++; $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, exp_frames);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all_zero();
    test_all_ones();
    test_single_pixel();
    test_backpressure();
    test_reset_mid_conv();
    test_random_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cnn_stream_classifier.md
Name: cnn_stream_classifier

Overview:
Sequential, parametrised successor to the combinational CNN classifier chain (conv → pad → pool → classify) for malaria cell images.
- Accepts a binary image one row per handshake and stores it in an internal frame buffer.
- Runs a 3x3 masked-popcount convolution one output pixel per cycle, then zero-padding plus 2x2 max-pooling one element per cycle, while accumulating a classification score.
- Presents result and score on a valid/ready output.

Parameters:
IMG_W, 16, image side in pixels; even, >= 4; padded feature map side also equals IMG_W.
FEAT_W, 4, feature element width; conv result saturates at 2^FEAT_W-1.
KERNEL, 9'h1FF, 3x3 binary weight mask; bit 3*kr+kc = kernel row kr, column kc.
THRESH, 300, result=1 iff score > THRESH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_row valid.
in_ready  out  1  block accepts a row (LOAD state only).
in_row  in  IMG_W  binary pixel row; bit c = column c; rows arrive in order 0..IMG_W-1.
out_valid  out  1  result/score valid.
out_ready  in  1  consumer accepts result.
result  out  1  1 = diseased, 0 = healthy.
score  out  SCORE_W  sum of pooled elements; SCORE_W = clog2((IMG_W/2)^2*(2^FEAT_W-1)+1).
busy  out  1  high in CONV, POOL, DONE.

Behaviour:
Reset:
- rst sampled at clk edge.
- Next state LOAD; row, pixel and pool counters = 0; score accumulator = 0.
- out_valid=0, result=0, score=0.
- in_ready is forced 0 while rst=1.
- Reset mid-frame discards all buffered data; no stale out_valid.

States: LOAD → CONV → POOL → DONE → LOAD.

LOAD:
- in_ready=1. Each in_valid&&in_ready edge writes in_row to buffer row[cnt] and increments cnt.
- Gaps in in_valid are allowed.
- The handshake on row IMG_W-1 moves to CONV.

CONV:
- One feature element per cycle, raster order, (IMG_W-2)^2 cycles.
- f(i,j) = popcount over kr,kc in 0..2 of img[i+kr][j+kc] & KERNEL[3*kr+kc]; saturate to FEAT_W bits.
- Stored in feature buffer.

Padding (implicit):
- p(r,c) = f(r-1,c-1) for 1 <= r,c <= IMG_W-2, else 0.
- No padded buffer is stored.

POOL:
- One pooled element per cycle, raster order, (IMG_W/2)^2 cycles.
- q(a,b) = max of p(2a..2a+1, 2b..2b+1).
- Score accumulator += q each cycle.

DONE:
- score and result registered on entry; out_valid=1.
- Outputs held stable until out_ready=1 at an edge; then LOAD, out_valid=0 next cycle.
- in_ready=0 throughout DONE, so no frame overlap.

Latency:
- out_valid rises exactly (IMG_W-2)^2 + (IMG_W/2)^2 edges after the final-row handshake edge (260 for IMG_W=16).

Arithmetic:
- All values are unsigned.
- The accumulator is SCORE_W wide and cannot overflow.
- Compare is strict greater-than.

in_valid while not in LOAD: ignored, not stored.

Optional Feature:
Macro: CNN_FRAME_CNT_EN.
- Defined: adds output frame_cnt[15:0], reset 0, incremented on each out_valid&&out_ready handshake, wraps 0xFFFF→0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
Shared package cnn_pkg:
- State enum (LOAD, CONV, POOL, DONE).
- clog2 function, saturating-resize function.
- Default IMG_W, FEAT_W.

Sub-module cnn_conv3x3_pe:
- Combinational: 9-bit window + KERNEL → saturated FEAT_W popcount.
- Instantiated once.

Test Plan:
1. All-zero image, default params → out_valid exactly 260 cycles after last row handshake; score=0, result=0.
2. All-ones image, KERNEL=9'h1FF, THRESH=500 → every f=9, every q=9, score=576, result=1.
3. Single pixel at row 5 col 5, KERNEL=9'h1FF → f=1 at i,j in 3..5; q=1 at (2,2),(2,3),(3,2),(3,3); score=4, result=0.
4. out_ready held 0 for 50 cycles in DONE → out_valid, result, score stable, in_ready=0; after handshake, in_ready=1 next cycle and next frame is processed correctly.
5. rst pulsed during CONV cycle 100 → out_valid=0, in_ready=1 after release; a following all-ones frame yields score=576.
6. in_valid toggled randomly during LOAD → only handshaked rows stored, result matches reference model; with CNN_FRAME_CNT_EN, frame_cnt=3 after three frames.
